// File: rtl/ram_sp_pipe_be_pkg.sv
// Purpose: shared defaults, FSM state encoding and byte-enable width helper for ram_sp_pipe_be.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_sp_pipe_be_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_RD_LATENCY = 1;

    // CLEAR walks the array writing zeros after reset; READY serves requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // One enable bit per byte lane of the data word.
    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_sp_pipe_be_rd_pipe.sv
// Purpose: optional extra output register stage for read data, valid and err.
// Latency: STAGES cycles (0 = pass-through, 1 = one register).
// Backpressure: none; data register only loads on valid so it holds otherwise.
//
// Ports:
//   clk, flush_n    clock and synchronous active-low flush
//   vld_i/dat_i/err_i  response from the array stage
//   vld_o/dat_o/err_o  delayed response
module ram_rd_pipe
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 0
) (
    input  logic                  clk,
    input  logic                  flush_n,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  err_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  err_o
);

    generate
        if (STAGES != 0 && STAGES != 1) begin : g_bad_stages
            $error("ram_rd_pipe: STAGES must be 0 or 1");
        end

        if (STAGES == 0) begin : g_bypass
            // Clock and flush are not needed without a register stage.
            logic unused_in;
            assign unused_in = clk ^ flush_n;
            assign vld_o = vld_i;
            assign dat_o = dat_i;
            assign err_o = err_i;
        end else begin : g_reg
            logic                  vld_q;
            logic [DATA_WIDTH-1:0] dat_q;
            logic                  err_q;
            logic [DATA_WIDTH-1:0] dat_d;

            // Hold the last word while no response is moving through.
            assign dat_d = vld_i ? dat_i : dat_q;

            always_ff @(posedge clk) begin
                if (!flush_n) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                    err_q <= 1'b0;
                end else begin
                    vld_q <= vld_i;
                    dat_q <= dat_d;
                    err_q <= err_i;
                end
            end

            assign vld_o = vld_q;
            assign dat_o = dat_q;
            assign err_o = err_q;
        end
    endgenerate

endmodule

// File: rtl/ram_sp_pipe_be.sv
// Purpose: single-port RAM with byte enables, post-reset clear sequence and range checking.
// Latency: reads return RD_LATENCY (1 or 2) cycles after the request edge; writes take effect on the request edge.
// Backpressure: none; while busy requests are dropped and flagged on err the following cycle.
//
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   en, wr_rd, addr        request strobe, 1=write/0=read, word address
//   data_in, be            write data and per-byte enables
//   data_out, en_out       read data and its one-cycle valid
//   busy                   high while the array is being zeroed
//   err                    one-cycle pulse on a rejected request
module ram_sp_pipe_be
    import ram_sp_pipe_be_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int  DEPTH      = DEF_DEPTH,
    parameter int  RD_LATENCY = DEF_RD_LATENCY,
    localparam int BE_WIDTH   = be_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  en_out,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]    LAST_PTR = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
            $error("ram_sp_pipe_be: RD_LATENCY must be 1 or 2");
        end
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_dw
            $error("ram_sp_pipe_be: DATA_WIDTH must be a non-zero multiple of 8");
        end
        if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("ram_sp_pipe_be: DEPTH must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

    state_t                state_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  side_err_q, side_err_d;

    logic                  ready;
    logic                  in_range;
    logic                  acc_wr;
    logic                  acc_rd;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  pipe_err;

    assign ready    = (state_q == ST_READY);
    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign mem_idx  = addr[IDX_W-1:0];
    assign rd_word  = mem_q[mem_idx];

    // Out-of-range reads still produce a response (zero data, err set) so
    // the requester always sees exactly one en_out per accepted read.
    assign acc_wr = ready & en &  wr_rd & in_range;
    assign acc_rd = ready & en & ~wr_rd;

    always_comb begin
        rsp_vld_d = acc_rd;
        rsp_err_d = acc_rd & ~in_range;
        rsp_dat_d = rsp_dat_q;
        if (acc_rd) begin
            rsp_dat_d = in_range ? rd_word : '0;
        end
        // Rejections with no read response: busy, or write out of range.
        side_err_d = en & (~ready | (wr_rd & ~in_range));
    end

    // Storage: zeroed one word per cycle during CLEAR, byte-masked writes after.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[ptr_q] <= '0;
            end else if (acc_wr) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (be[i]) begin
                        mem_q[mem_idx][8*i +: 8] <= data_in[8*i +: 8];
                    end
                end
            end
        end
    end

    // Control FSM and first response stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_dat_q  <= '0;
            rsp_err_q  <= 1'b0;
            side_err_q <= 1'b0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_dat_q  <= rsp_dat_d;
            rsp_err_q  <= rsp_err_d;
            side_err_q <= side_err_d;
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == LAST_PTR) begin
                        state_q <= ST_READY;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign busy = (state_q == ST_CLEAR);

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY - 1)
    ) u_rd_pipe (
        .clk     (clk),
        .flush_n (rst),
        .vld_i   (rsp_vld_q),
        .dat_i   (rsp_dat_q),
        .err_i   (rsp_err_q),
        .vld_o   (en_out),
        .dat_o   (data_out),
        .err_o   (pipe_err)
    );

    assign err = pipe_err | side_err_q;

endmodule

// File: tb/tb_ram_sp_pipe_be.sv
module tb_ram_sp_pipe_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_rd;
    logic [3:0]  addr;
    logic [31:0] data_in;
    logic [3:0]  be;

    logic [31:0] dout_a, dout_b;
    logic        vld_a, vld_b, err_a, err_b, busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance A: depth 16, latency 1.  Instance B: depth 12, latency 2.
    ram_sp_pipe_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .wr_rd(wr_rd), .addr(addr), .data_in(data_in), .be(be),
        .data_out(dout_a), .en_out(vld_a), .busy(busy_a), .err(err_a)
    );

    ram_sp_pipe_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(2)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .wr_rd(wr_rd), .addr(addr), .data_in(data_in), .be(be),
        .data_out(dout_b), .en_out(vld_b), .busy(busy_b), .err(err_b)
    );

    // Reference model state, index 0 = A, 1 = B.
    logic [31:0] mm [2][16];
    int          cnt [2];      // edges since reset release, saturating at depth
    logic        pv [2];       // response waiting one more cycle (latency 2)
    logic [31:0] pd [2];
    logic        pe [2];
    logic        ex_v [2];
    logic [31:0] ex_d [2];
    logic        ex_e [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic w,
                              input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        int   dep;
        int   lat;
        logic cv, ce, side;
        logic [31:0] cd;
        for (int k = 0; k < 2; k++) begin
            dep = (k == 0) ? 16 : 12;
            lat = (k == 0) ? 1 : 2;
            if (!r) begin
                cnt[k] = 0;
                pv[k] = 1'b0; pd[k] = '0; pe[k] = 1'b0;
                ex_v[k] = 1'b0; ex_d[k] = '0; ex_e[k] = 1'b0;
                for (int j = 0; j < 16; j++) mm[k][j] = '0;
            end else begin
                cv = 1'b0; ce = 1'b0; cd = '0; side = 1'b0;
                if (e) begin
                    if (cnt[k] < dep) begin
                        side = 1'b1;
                    end else if (int'(a) >= dep) begin
                        if (w) side = 1'b1;
                        else begin cv = 1'b1; ce = 1'b1; end
                    end else if (w) begin
                        for (int i = 0; i < 4; i++)
                            if (b[i]) mm[k][a][8*i +: 8] = d[8*i +: 8];
                    end else begin
                        cv = 1'b1;
                        cd = mm[k][a];
                    end
                end
                if (cnt[k] < dep) cnt[k]++;
                if (lat == 1) begin
                    ex_v[k] = cv;
                    ex_e[k] = ce | side;
                    if (cv) ex_d[k] = cd;
                end else begin
                    ex_v[k] = pv[k];
                    ex_e[k] = pe[k] | side;
                    if (pv[k]) ex_d[k] = pd[k];
                    pv[k] = cv; pd[k] = cd; pe[k] = ce;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("a_busy", 32'(busy_a), 32'(cnt[0] < 16));
        chk("a_vld",  32'(vld_a),  32'(ex_v[0]));
        chk("a_err",  32'(err_a),  32'(ex_e[0]));
        chk("a_dout", dout_a,      ex_d[0]);
        chk("b_busy", 32'(busy_b), 32'(cnt[1] < 12));
        chk("b_vld",  32'(vld_b),  32'(ex_v[1]));
        chk("b_err",  32'(err_b),  32'(ex_e[1]));
        chk("b_dout", dout_b,      ex_d[1]);
    endtask

    task automatic step(input logic r, input logic e, input logic w,
                        input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        rst = r; en = e; wr_rd = w; addr = a; data_in = d; be = b;
        @(posedge clk);
        #1;
        model_step(r, e, w, a, d, b);
        compare_all();
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    endtask

    // Clock edges until busy_a drops, bounded; returns edges taken.
    task automatic wait_clear(output int n);
        n = 0;
        while (busy_a && n < 40) begin
            idle();
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; en = 1'b0; wr_rd = 1'b0; addr = '0; data_in = '0; be = '0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_vld",  32'(vld_a),  32'd0);
        chk("rst_err",  32'(err_a),  32'd0);
        chk("rst_dout", dout_a,      32'd0);

        // Clear sequence: 16 busy cycles, then every word reads zero
        wait_clear(n);
        chk("clear_len", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'(i), 32'd0, 4'd0);
            chk("clear_rd_vld", 32'(vld_a), 32'd1);
            chk("clear_rd_dat", dout_a, 32'd0);
        end
        idle(); idle();

        // Byte-enable merge
        step(1'b1, 1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b1111);
        step(1'b1, 1'b1, 1'b1, 4'd3, 32'h11223344, 4'b0101);
        step(1'b1, 1'b1, 1'b0, 4'd3, 32'd0, 4'd0);
        chk("be_merge_a", dout_a, 32'hAA22CC44);
        idle();
        chk("be_merge_b", dout_b, 32'hAA22CC44);
        step(1'b1, 1'b1, 1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000);   // be=0 no-op
        step(1'b1, 1'b1, 1'b0, 4'd3, 32'd0, 4'd0);
        chk("be_zero_a", dout_a, 32'hAA22CC44);
        idle(); idle();

        // Latency and throughput: 4 writes, 4 back-to-back reads
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b1, 4'(i), 32'((i + 1) * 16), 4'hF);
        for (int s = 0; s < 8; s++) begin
            if (s < 4) step(1'b1, 1'b1, 1'b0, 4'(s), 32'd0, 4'd0);
            else       idle();
            chk("lat2_vld", 32'(vld_b), 32'(s >= 1 && s <= 4));
            if (s >= 1 && s <= 4) chk("lat2_dat", dout_b, 32'(s * 16));
            chk("lat1_vld", 32'(vld_a), 32'(s <= 3));
            if (s <= 3) chk("lat1_dat", dout_a, 32'((s + 1) * 16));
        end

        // Out-of-range on the depth-12 instance
        step(1'b1, 1'b1, 1'b1, 4'd13, 32'hDEADBEEF, 4'hF);
        chk("oor_wr_err", 32'(err_b), 32'd1);
        chk("oor_wr_vld", 32'(vld_b), 32'd0);
        idle();
        chk("oor_wr_once", 32'(err_b), 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'd13, 32'd0, 4'd0);
        chk("oor_rd_early", 32'(vld_b), 32'd0);
        chk("a13_dat", dout_a, 32'hDEADBEEF);
        idle();
        chk("oor_rd_vld", 32'(vld_b), 32'd1);
        chk("oor_rd_err", 32'(err_b), 32'd1);
        chk("oor_rd_dat", dout_b, 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'd1, 32'd0, 4'd0);
        idle();
        chk("oor_mem_kept", dout_b, 32'h20);
        idle(); idle();

        // Busy rejection: read in cycle 5 of the clear
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        n = 0;
        do begin
            step(1'b1, (n == 4), 1'b0, 4'd2, 32'd0, 4'd0);
            n++;
            if (n == 5) begin
                chk("rej_err", 32'(err_a), 32'd1);
                chk("rej_vld", 32'(vld_a), 32'd0);
            end
            if (n == 6) chk("rej_err_once", 32'(err_a), 32'd0);
        end while (busy_a && n < 40);
        chk("rej_busy_len", 32'(n), 32'd16);

        // Reset at cycle 8 of the clear with a read in flight
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        for (int c = 1; c <= 7; c++)
            step(1'b1, (c == 7), 1'b0, 4'd1, 32'd0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd1, 32'd0, 4'd0);
        chk("mid_rst_vld",  32'(vld_a),  32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd1);
        wait_clear(n);
        chk("mid_rst_len", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'(i), 32'd0, 4'd0);
            chk("mid_rst_rd", dout_a, 32'd0);
        end
        idle(); idle();

        // Randomised traffic against the model, with rare resets
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 199) == 0)
                step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
            else
                step(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sp_pipe_be.md
Name: ram_sp_pipe_be

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed-size RAM block.
- Adds per-byte write enables, selectable 1- or 2-cycle read latency, and a sequenced post-reset clear with a busy flag.
- Adds out-of-range address detection for non-power-of-2 depths.
- Sits between bus-side request logic and storage; en_out is the read-response valid strobe.

Parameters:
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- ADDR_WIDTH, 4: address bus width.
- DEPTH, 16: number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- RD_LATENCY, 1: read latency in cycles; legal values 1 or 2.
- BE_WIDTH, DATA_WIDTH/8: byte-enable width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  request strobe, sampled each rising edge.
- wr_rd  in  1  1 = write, 0 = read.
- addr  in  ADDR_WIDTH  word address.
- data_in  in  DATA_WIDTH  write data.
- be  in  BE_WIDTH  byte enables; be[i] covers data_in[8i+7:8i].
- data_out  out  DATA_WIDTH  read data.
- en_out  out  1  read-data valid, one-cycle pulse per accepted read.
- busy  out  1  high during the post-reset clear; requests are not accepted.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (clk edge with rst=0):
  - State goes to CLEAR and the clear pointer goes to 0.
  - data_out=0, en_out=0, err=0, busy=1, read pipeline flushed.
  - All state holds while rst stays low.
- FSM states: CLEAR, READY.
- CLEAR:
  - On each edge with rst=1, writes 0 to mem[ptr] and increments ptr.
  - When ptr==DEPTH-1 is written, goes to READY; busy drops on that same edge.
  - busy is therefore high for exactly DEPTH cycles after rst release.
- Request while busy: ignored, memory untouched, err pulses on the next edge, en_out stays 0.
- Write (READY, en=1, wr_rd=1, addr<DEPTH):
  - Each byte with be[i]=1 is updated; bytes with be[i]=0 are kept.
  - be=0 is a legal no-op.
  - en_out=0 and err=0.
- Read (READY, en=1, wr_rd=0, addr<DEPTH):
  - RD_LATENCY=1: data_out and en_out update on the request edge.
  - RD_LATENCY=2: one extra register stage, so the response appears one edge later.
  - Back-to-back reads give a continuous en_out with one word per cycle, in order.
- data_out holds its last value when en_out=0.
- A write issued after a read to the same address does not disturb the pipelined read data; the old value is returned.
- Out-of-range access (addr>=DEPTH):
  - Write: dropped; err pulses one edge after the request.
  - Read: data_out=0, en_out=1, and err=1 aligned with en_out.
- en=0: no memory access; en_out deasserts once in-flight reads drain.
- Reset mid-clear or mid-read: pending responses are discarded and the clear restarts at ptr=0.
- Illegal RD_LATENCY or a DATA_WIDTH that is not a multiple of 8: elaboration-time error.

Decomposition:
- Shared package/defines holds:
  - default DATA_WIDTH, ADDR_WIDTH and DEPTH;
  - the CLEAR/READY state encoding;
  - the BE_WIDTH derivation macro.
- One sub-module, ram_rd_pipe: the parametrised output register stage carrying data, valid and err.
  - Instantiated with 0 or 1 extra stages depending on RD_LATENCY.
  - Has its own synchronous active-low flush.

Test Plan:
- Clear sequence: DEPTH=16, release rst. Required: busy=1 for exactly 16 cycles, then 0. Reading addresses 0..15 returns 0x00000000 with en_out on every read.
- Byte-enable write: write 0xAABBCCDD with be=1111 to addr 3, then 0x11223344 with be=0101 to addr 3, then read addr 3. Required: data_out=0xAA22CC44.
- Latency and throughput: RD_LATENCY=2; write 0x10,0x20,0x30,0x40 to addrs 0..3, then issue 4 consecutive reads. Required: en_out high for 4 consecutive cycles starting 2 edges after the first read; data_out is 0x10,0x20,0x30,0x40 in order.
- Out-of-range: DEPTH=12, ADDR_WIDTH=4.
  - Write to addr 13: err pulses once, memory unchanged.
  - Read addr 13: en_out=1, err=1, data_out=0.
- Busy rejection: issue a read in cycle 5 of the clear. Required: err pulses once, en_out=0, and busy timing is unaffected.
- Reset mid-operation: assert rst for 1 cycle at cycle 8 of the clear, with a read in flight. Required: en_out suppressed, busy high for a full 16 cycles after the second release, and all words read back 0.
